// File: rtl/ahbl_arbiter_2.sv
// Two-master AHB-Lite arbiter: the non-owner's address phase is parked in a
// holding register and replayed once that master wins the bus.
//   owner | meaning
//   0     | M0 drives the address phase (M0 wins ties under fixed priority)
//   1     | M1 drives the address phase
module ahbl_arbiter_2 #(
  parameter int ARB_RR = 1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] M0_HADDR,
  input  logic [1:0]  M0_HTRANS,
  input  logic        M0_HWRITE,
  input  logic [2:0]  M0_HSIZE,
  input  logic [2:0]  M0_HBURST,
  input  logic [31:0] M0_HWDATA,
  output logic        M0_HREADY,
  output logic [31:0] M0_HRDATA,
  input  logic [31:0] M1_HADDR,
  input  logic [1:0]  M1_HTRANS,
  input  logic        M1_HWRITE,
  input  logic [2:0]  M1_HSIZE,
  input  logic [2:0]  M1_HBURST,
  input  logic [31:0] M1_HWDATA,
  output logic        M1_HREADY,
  output logic [31:0] M1_HRDATA,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [31:0] HRDATA,
  output logic        HMASTER
);

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  logic        owner, downer, dactive, pend0, pend1;
  logic        next_owner;
  logic [3:0]  bcnt, burst_len;
  logic [31:0] p0_addr, p1_addr;
  logic [1:0]  p0_trans, p1_trans;
  logic        p0_write, p1_write;
  logic [2:0]  p0_size, p1_size, p0_burst, p1_burst;
  logic        acc0, acc1, req0, req1, fixed_burst, decision;

  always_comb begin
    HADDR  = M0_HADDR;
    HTRANS = M0_HTRANS;
    HWRITE = M0_HWRITE;
    HSIZE  = M0_HSIZE;
    HBURST = M0_HBURST;
    if (!owner && pend0) begin
      HADDR  = p0_addr;
      HTRANS = p0_trans;
      HWRITE = p0_write;
      HSIZE  = p0_size;
      HBURST = p0_burst;
    end else if (owner && pend1) begin
      HADDR  = p1_addr;
      HTRANS = p1_trans;
      HWRITE = p1_write;
      HSIZE  = p1_size;
      HBURST = p1_burst;
    end else if (owner) begin
      HADDR  = M1_HADDR;
      HTRANS = M1_HTRANS;
      HWRITE = M1_HWRITE;
      HSIZE  = M1_HSIZE;
      HBURST = M1_HBURST;
    end
  end

  assign HWDATA    = downer ? M1_HWDATA : M0_HWDATA;
  assign HMASTER   = owner;
  assign M0_HRDATA = HRDATA;
  assign M1_HRDATA = HRDATA;

  // A master with a parked phase is stalled until that phase reaches the bus
  assign M0_HREADY = pend0 ? 1'b0 : ((!owner || (dactive && !downer)) ? HREADY : 1'b1);
  assign M1_HREADY = pend1 ? 1'b0 : ((owner || (dactive && downer)) ? HREADY : 1'b1);

  assign acc0 = M0_HREADY && M0_HTRANS[1];
  assign acc1 = M1_HREADY && M1_HTRANS[1];
  assign req0 = pend0 || M0_HTRANS[1];
  assign req1 = pend1 || M1_HTRANS[1];

  assign fixed_burst = (HBURST[2:1] != 2'b00);
  assign decision = HREADY && ((HTRANS == HT_IDLE) ||
                               (HTRANS == HT_NONSEQ && HBURST == 3'b000) ||
                               (HTRANS == HT_SEQ && fixed_burst && bcnt == 4'd1));

  always_comb begin
    case (HBURST[2:1])
      2'b01:   burst_len = 4'd3;
      2'b10:   burst_len = 4'd7;
      2'b11:   burst_len = 4'd15;
      default: burst_len = 4'd0;
    endcase
  end

  always_comb begin
    next_owner = owner;
    if (decision) begin
      if (ARB_RR != 0) begin
        if (!owner && req1)     next_owner = 1'b1;
        else if (owner && req0) next_owner = 1'b0;
      end else begin
        if (req0)      next_owner = 1'b0;
        else if (req1) next_owner = 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      owner   <= 1'b0;
      downer  <= 1'b0;
      dactive <= 1'b0;
      pend0   <= 1'b0;
      pend1   <= 1'b0;
      bcnt    <= 4'd0;
    end else begin
      owner <= next_owner;
      if (HREADY) begin
        downer  <= owner;
        dactive <= HTRANS[1];
        if (HTRANS == HT_NONSEQ && fixed_burst) bcnt <= burst_len;
        else if (HTRANS == HT_SEQ && bcnt != 4'd0) bcnt <= bcnt - 4'd1;
      end
      if (acc0 && owner)              pend0 <= 1'b1;
      else if (!owner && HREADY)      pend0 <= 1'b0;
      if (acc1 && !owner)             pend1 <= 1'b1;
      else if (owner && HREADY)       pend1 <= 1'b0;
    end
  end

  // Holding registers need no reset: they are only visible while pendx=1
  always_ff @(posedge HCLK) begin
    if (acc0 && owner) begin
      p0_addr  <= M0_HADDR;
      p0_trans <= M0_HTRANS;
      p0_write <= M0_HWRITE;
      p0_size  <= M0_HSIZE;
      p0_burst <= M0_HBURST;
    end
    if (acc1 && !owner) begin
      p1_addr  <= M1_HADDR;
      p1_trans <= M1_HTRANS;
      p1_write <= M1_HWRITE;
      p1_size  <= M1_HSIZE;
      p1_burst <= M1_HBURST;
    end
  end

endmodule

// File: tb/tb_ahbl_arbiter_2.sv
// Directed bench for ahbl_arbiter_2: round-robin instance checked throughout,
// fixed-priority instance checked under streaming contention.
module tb_ahbl_arbiter_2;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [31:0] M0_HADDR, M1_HADDR, M0_HWDATA, M1_HWDATA, HRDATA;
  logic [1:0]  M0_HTRANS, M1_HTRANS;
  logic        M0_HWRITE, M1_HWRITE, HREADY;
  logic [2:0]  M0_HSIZE, M1_HSIZE, M0_HBURST, M1_HBURST;

  logic        M0_HREADY, M1_HREADY, HWRITE, HMASTER;
  logic [31:0] M0_HRDATA, M1_HRDATA, HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;

  logic        fp_M0_HREADY, fp_M1_HREADY, fp_HWRITE, fp_HMASTER;
  logic [31:0] fp_M0_HRDATA, fp_M1_HRDATA, fp_HADDR, fp_HWDATA;
  logic [1:0]  fp_HTRANS;
  logic [2:0]  fp_HSIZE, fp_HBURST;

  int n_cmp = 0;
  int n_err = 0;

  always #5 HCLK = ~HCLK;

  ahbl_arbiter_2 #(.ARB_RR(1)) u_rr (
    .HCLK(HCLK), .HRESET(HRESET),
    .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE), .M0_HSIZE(M0_HSIZE),
    .M0_HBURST(M0_HBURST), .M0_HWDATA(M0_HWDATA), .M0_HREADY(M0_HREADY), .M0_HRDATA(M0_HRDATA),
    .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE), .M1_HSIZE(M1_HSIZE),
    .M1_HBURST(M1_HBURST), .M1_HWDATA(M1_HWDATA), .M1_HREADY(M1_HREADY), .M1_HRDATA(M1_HRDATA),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA), .HMASTER(HMASTER)
  );

  ahbl_arbiter_2 #(.ARB_RR(0)) u_fp (
    .HCLK(HCLK), .HRESET(HRESET),
    .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE), .M0_HSIZE(M0_HSIZE),
    .M0_HBURST(M0_HBURST), .M0_HWDATA(M0_HWDATA), .M0_HREADY(fp_M0_HREADY), .M0_HRDATA(fp_M0_HRDATA),
    .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE), .M1_HSIZE(M1_HSIZE),
    .M1_HBURST(M1_HBURST), .M1_HWDATA(M1_HWDATA), .M1_HREADY(fp_M1_HREADY), .M1_HRDATA(fp_M1_HRDATA),
    .HADDR(fp_HADDR), .HTRANS(fp_HTRANS), .HWRITE(fp_HWRITE), .HSIZE(fp_HSIZE), .HBURST(fp_HBURST),
    .HWDATA(fp_HWDATA), .HREADY(HREADY), .HRDATA(HRDATA), .HMASTER(fp_HMASTER)
  );

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    M0_HADDR = 32'hA5A5_0000;
    cyc(); cyc();
    HREADY = 1'b0; #1;
    n_cmp++; if (HMASTER !== 1'b0) begin n_err++; $display("FAIL reset_hmaster: got %0h expected 0", HMASTER); end
    n_cmp++; if (HADDR !== 32'hA5A5_0000) begin n_err++; $display("FAIL reset_haddr: got %0h expected a5a50000", HADDR); end
    n_cmp++; if (M0_HREADY !== 1'b0) begin n_err++; $display("FAIL reset_m0_hready_lo: got %0h expected 0", M0_HREADY); end
    n_cmp++; if (M1_HREADY !== 1'b1) begin n_err++; $display("FAIL reset_m1_hready: got %0h expected 1", M1_HREADY); end
    n_cmp++; if (fp_HMASTER !== 1'b0) begin n_err++; $display("FAIL reset_fp_hmaster: got %0h expected 0", fp_HMASTER); end
    HREADY = 1'b1; #1;
    n_cmp++; if (M0_HREADY !== 1'b1) begin n_err++; $display("FAIL reset_m0_hready_hi: got %0h expected 1", M0_HREADY); end
    HRESET = 1'b0;
    cyc();
  endtask

  task automatic test_single_read();
    M0_HADDR = 32'h10; M0_HTRANS = 2'b10; M0_HWRITE = 1'b0; M0_HSIZE = 3'd2; M0_HBURST = 3'b000;
    #1;
    n_cmp++; if (HADDR !== 32'h10) begin n_err++; $display("FAIL single_haddr: got %0h expected 10", HADDR); end
    n_cmp++; if (HTRANS !== 2'b10) begin n_err++; $display("FAIL single_htrans: got %0h expected 2", HTRANS); end
    n_cmp++; if (HMASTER !== 1'b0) begin n_err++; $display("FAIL single_hmaster_a: got %0h expected 0", HMASTER); end
    cyc();
    M0_HTRANS = 2'b00; HRDATA = 32'hDEAD_BEEF; #1;
    n_cmp++; if (M0_HRDATA !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL single_m0_hrdata: got %0h expected deadbeef", M0_HRDATA); end
    n_cmp++; if (M1_HRDATA !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL single_m1_hrdata: got %0h expected deadbeef", M1_HRDATA); end
    n_cmp++; if (M0_HREADY !== 1'b1) begin n_err++; $display("FAIL single_m0_hready: got %0h expected 1", M0_HREADY); end
    n_cmp++; if (HMASTER !== 1'b0) begin n_err++; $display("FAIL single_hmaster_d: got %0h expected 0", HMASTER); end
    cyc();
  endtask

  task automatic test_capture_write();
    M0_HWDATA = 32'h1111_1111;
    M1_HADDR = 32'h2000_0000; M1_HTRANS = 2'b10; M1_HWRITE = 1'b1; M1_HSIZE = 3'd2; M1_HBURST = 3'b000;
    #1;
    n_cmp++; if (M1_HREADY !== 1'b1) begin n_err++; $display("FAIL cap_m1_hready_a: got %0h expected 1", M1_HREADY); end
    n_cmp++; if (HMASTER !== 1'b0) begin n_err++; $display("FAIL cap_hmaster_a: got %0h expected 0", HMASTER); end
    cyc();
    M1_HTRANS = 2'b00; M1_HADDR = 32'h0; M1_HWRITE = 1'b0; M1_HWDATA = 32'hCAFE_0001; #1;
    n_cmp++; if (HMASTER !== 1'b1) begin n_err++; $display("FAIL cap_hmaster_b: got %0h expected 1", HMASTER); end
    n_cmp++; if (HADDR !== 32'h2000_0000) begin n_err++; $display("FAIL cap_haddr: got %0h expected 20000000", HADDR); end
    n_cmp++; if (HWRITE !== 1'b1) begin n_err++; $display("FAIL cap_hwrite: got %0h expected 1", HWRITE); end
    n_cmp++; if (HTRANS !== 2'b10) begin n_err++; $display("FAIL cap_htrans: got %0h expected 2", HTRANS); end
    n_cmp++; if (M1_HREADY !== 1'b0) begin n_err++; $display("FAIL cap_m1_hready_b: got %0h expected 0", M1_HREADY); end
    cyc();
    #1;
    n_cmp++; if (HWDATA !== 32'hCAFE_0001) begin n_err++; $display("FAIL cap_hwdata: got %0h expected cafe0001", HWDATA); end
    n_cmp++; if (M1_HREADY !== 1'b1) begin n_err++; $display("FAIL cap_m1_hready_c: got %0h expected 1", M1_HREADY); end
    n_cmp++; if (HMASTER !== 1'b1) begin n_err++; $display("FAIL cap_hmaster_c: got %0h expected 1", HMASTER); end
    cyc();
  endtask

  task automatic test_burst_switch();
    M0_HADDR = 32'h100; M0_HTRANS = 2'b10; M0_HBURST = 3'b011; M0_HWRITE = 1'b0; #1;
    n_cmp++; if (M0_HREADY !== 1'b1) begin n_err++; $display("FAIL burst_m0_hready_0: got %0h expected 1", M0_HREADY); end
    n_cmp++; if (HMASTER !== 1'b1) begin n_err++; $display("FAIL burst_hmaster_0: got %0h expected 1", HMASTER); end
    cyc();
    M0_HADDR = 32'h104; M0_HTRANS = 2'b11; #1;
    n_cmp++; if (HADDR !== 32'h100) begin n_err++; $display("FAIL burst_haddr_1: got %0h expected 100", HADDR); end
    n_cmp++; if (HTRANS !== 2'b10) begin n_err++; $display("FAIL burst_htrans_1: got %0h expected 2", HTRANS); end
    n_cmp++; if (HMASTER !== 1'b0) begin n_err++; $display("FAIL burst_hmaster_1: got %0h expected 0", HMASTER); end
    n_cmp++; if (M0_HREADY !== 1'b0) begin n_err++; $display("FAIL burst_m0_hready_1: got %0h expected 0", M0_HREADY); end
    cyc();
    M1_HADDR = 32'h3000_0000; M1_HTRANS = 2'b10; M1_HWRITE = 1'b0; M1_HBURST = 3'b000; #1;
    n_cmp++; if (HADDR !== 32'h104) begin n_err++; $display("FAIL burst_haddr_2: got %0h expected 104", HADDR); end
    n_cmp++; if (HTRANS !== 2'b11) begin n_err++; $display("FAIL burst_htrans_2: got %0h expected 3", HTRANS); end
    n_cmp++; if (M1_HREADY !== 1'b1) begin n_err++; $display("FAIL burst_m1_hready_2: got %0h expected 1", M1_HREADY); end
    cyc();
    M0_HADDR = 32'h108; M1_HTRANS = 2'b00; M1_HADDR = 32'h0; #1;
    n_cmp++; if (HADDR !== 32'h108) begin n_err++; $display("FAIL burst_haddr_3: got %0h expected 108", HADDR); end
    n_cmp++; if (HMASTER !== 1'b0) begin n_err++; $display("FAIL burst_hmaster_3: got %0h expected 0", HMASTER); end
    n_cmp++; if (M1_HREADY !== 1'b0) begin n_err++; $display("FAIL burst_m1_hready_3: got %0h expected 0", M1_HREADY); end
    cyc();
    M0_HADDR = 32'h10C; #1;
    n_cmp++; if (HADDR !== 32'h10C) begin n_err++; $display("FAIL burst_haddr_4: got %0h expected 10c", HADDR); end
    n_cmp++; if (HMASTER !== 1'b0) begin n_err++; $display("FAIL burst_hmaster_4: got %0h expected 0", HMASTER); end
    cyc();
    M0_HTRANS = 2'b00; M0_HBURST = 3'b000; #1;
    n_cmp++; if (HMASTER !== 1'b1) begin n_err++; $display("FAIL burst_hmaster_5: got %0h expected 1", HMASTER); end
    n_cmp++; if (HADDR !== 32'h3000_0000) begin n_err++; $display("FAIL burst_haddr_5: got %0h expected 30000000", HADDR); end
    n_cmp++; if (HTRANS !== 2'b10) begin n_err++; $display("FAIL burst_htrans_5: got %0h expected 2", HTRANS); end
    n_cmp++; if (M0_HREADY !== 1'b1) begin n_err++; $display("FAIL burst_m0_hready_5: got %0h expected 1", M0_HREADY); end
    cyc();
    #1;
    n_cmp++; if (M1_HREADY !== 1'b1) begin n_err++; $display("FAIL burst_m1_hready_6: got %0h expected 1", M1_HREADY); end
    n_cmp++; if (HTRANS !== 2'b00) begin n_err++; $display("FAIL burst_htrans_6: got %0h expected 0", HTRANS); end
    cyc();
  endtask

  task automatic test_stall();
    M1_HADDR = 32'h4000_0000; M1_HTRANS = 2'b10; M1_HWRITE = 1'b1; #1;
    n_cmp++; if (M1_HREADY !== 1'b1) begin n_err++; $display("FAIL stall_m1_hready_a: got %0h expected 1", M1_HREADY); end
    n_cmp++; if (HADDR !== 32'h4000_0000) begin n_err++; $display("FAIL stall_haddr: got %0h expected 40000000", HADDR); end
    cyc();
    M1_HTRANS = 2'b00; M1_HWRITE = 1'b0; HREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (M1_HREADY !== 1'b0) begin n_err++; $display("FAIL stall_m1_hready_%0d: got %0h expected 0", i, M1_HREADY); end
      n_cmp++; if (HMASTER !== 1'b1) begin n_err++; $display("FAIL stall_hmaster_%0d: got %0h expected 1", i, HMASTER); end
      n_cmp++; if (u_rr.downer !== 1'b1) begin n_err++; $display("FAIL stall_downer_%0d: got %0h expected 1", i, u_rr.downer); end
      n_cmp++; if (u_rr.pend1 !== 1'b0) begin n_err++; $display("FAIL stall_pend1_%0d: got %0h expected 0", i, u_rr.pend1); end
      cyc();
    end
    HREADY = 1'b1; #1;
    n_cmp++; if (M1_HREADY !== 1'b1) begin n_err++; $display("FAIL stall_m1_hready_b: got %0h expected 1", M1_HREADY); end
    cyc();
  endtask

  task automatic test_reset_pending();
    M0_HADDR = 32'h60; M0_HTRANS = 2'b10; M0_HBURST = 3'b000;
    M1_HADDR = 32'h7000_0000; M1_HTRANS = 2'b10; M1_HBURST = 3'b000; #1;
    n_cmp++; if (M0_HREADY !== 1'b1) begin n_err++; $display("FAIL rstp_m0_hready: got %0h expected 1", M0_HREADY); end
    n_cmp++; if (HADDR !== 32'h7000_0000) begin n_err++; $display("FAIL rstp_haddr_0: got %0h expected 70000000", HADDR); end
    cyc();
    M0_HTRANS = 2'b00; M1_HADDR = 32'h7000_0004; #1;
    n_cmp++; if (HADDR !== 32'h60) begin n_err++; $display("FAIL rstp_haddr_1: got %0h expected 60", HADDR); end
    n_cmp++; if (HMASTER !== 1'b0) begin n_err++; $display("FAIL rstp_hmaster_1: got %0h expected 0", HMASTER); end
    n_cmp++; if (M1_HREADY !== 1'b1) begin n_err++; $display("FAIL rstp_m1_hready_1: got %0h expected 1", M1_HREADY); end
    cyc();
    M1_HTRANS = 2'b00; M1_HADDR = 32'h0; #1;
    n_cmp++; if (HMASTER !== 1'b1) begin n_err++; $display("FAIL rstp_hmaster_2: got %0h expected 1", HMASTER); end
    n_cmp++; if (HADDR !== 32'h7000_0004) begin n_err++; $display("FAIL rstp_haddr_2: got %0h expected 70000004", HADDR); end
    n_cmp++; if (M1_HREADY !== 1'b0) begin n_err++; $display("FAIL rstp_m1_hready_2: got %0h expected 0", M1_HREADY); end
    HRESET = 1'b1;
    cyc();
    #1;
    n_cmp++; if (u_rr.pend1 !== 1'b0) begin n_err++; $display("FAIL rstp_pend1: got %0h expected 0", u_rr.pend1); end
    n_cmp++; if (HMASTER !== 1'b0) begin n_err++; $display("FAIL rstp_hmaster_3: got %0h expected 0", HMASTER); end
    n_cmp++; if (M1_HREADY !== 1'b1) begin n_err++; $display("FAIL rstp_m1_hready_3: got %0h expected 1", M1_HREADY); end
    n_cmp++; if (HADDR !== 32'h60) begin n_err++; $display("FAIL rstp_haddr_3: got %0h expected 60", HADDR); end
    HRESET = 1'b0;
    cyc();
  endtask

  task automatic test_back_to_back();
    logic exp_m;
    HRESET = 1'b1;
    cyc();
    HRESET = 1'b0;
    M0_HADDR = 32'h80; M0_HTRANS = 2'b10; M0_HBURST = 3'b000; M0_HWRITE = 1'b0;
    M1_HADDR = 32'h9000_0000; M1_HTRANS = 2'b10; M1_HBURST = 3'b000; M1_HWRITE = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_m = (i % 2 == 1);
      #1;
      n_cmp++; if (HMASTER !== exp_m) begin n_err++; $display("FAIL b2b_rr_hmaster_%0d: got %0h expected %0h", i, HMASTER, exp_m); end
      n_cmp++; if (fp_HMASTER !== 1'b0) begin n_err++; $display("FAIL b2b_fp_hmaster_%0d: got %0h expected 0", i, fp_HMASTER); end
      cyc();
    end
    M0_HTRANS = 2'b00; M1_HTRANS = 2'b00;
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESET = 1'b1; HREADY = 1'b1; HRDATA = 32'h0;
    M0_HADDR = 32'h0; M0_HTRANS = 2'b00; M0_HWRITE = 1'b0; M0_HSIZE = 3'd2; M0_HBURST = 3'b000; M0_HWDATA = 32'h0;
    M1_HADDR = 32'h0; M1_HTRANS = 2'b00; M1_HWRITE = 1'b0; M1_HSIZE = 3'd2; M1_HBURST = 3'b000; M1_HWDATA = 32'h0;
    #2;
    test_reset();
    test_single_read();
    test_capture_write();
    test_burst_switch();
    test_stall();
    test_reset_pending();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ahbl_arbiter_2.md
AHBL_ARBITER_2 -- requirements
Module: ahbl_arbiter_2

Interface
REQ-001 Parameter ARB_RR, default 1, meaning: 1 = round-robin, 0 = fixed priority with M0 highest.
REQ-002 HCLK  in  1  bus clock; all state updates on rising edge.
REQ-003 HRESET  in  1  reset; synchronous, active-high.
REQ-004 M0_HADDR/M1_HADDR  in  32  master address.
REQ-005 M0_HTRANS/M1_HTRANS  in  2  transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11).
REQ-006 M0_HWRITE/M1_HWRITE  in  1  write flag.
REQ-007 M0_HSIZE/M1_HSIZE  in  3  transfer size.
REQ-008 M0_HBURST/M1_HBURST  in  3  burst type (SINGLE=000, INCR=001, WRAP4/INCR4=010/011, 8-beat=100/101, 16-beat=110/111).
REQ-009 M0_HWDATA/M1_HWDATA  in  32  write data.
REQ-010 M0_HREADY/M1_HREADY  out  1  per-master ready.
REQ-011 M0_HRDATA/M1_HRDATA  out  32  read data; both equal HRDATA (broadcast).
REQ-012 HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA  out  32/2/1/3/3/32  arbitrated bus outputs.
REQ-013 HREADY  in  1  bus ready returned by the downstream splitter.
REQ-014 HRDATA  in  32  bus read data.
REQ-015 HMASTER  out  1  current address-phase owner (0 = M0, 1 = M1).

Function
REQ-016 State: owner (1b), downer (1b), dactive (1b), pend0/pend1 (1b each), PEND0/PEND1 holding registers (addr, trans, write, size, burst), beat counter bcnt (4b).
REQ-017 Master x "accepts" an address phase at any edge where Mx_HREADY=1 and Mx_HTRANS[1]=1.
REQ-018 An accept by the owner goes directly onto the bus; an accept by the non-owner is captured into PENDx and sets pendx=1.
REQ-019 Bus address/control outputs are PENDx if owner=x and pendx=1, else owner's live signals; HMASTER=owner.
REQ-020 pendx clears at the edge where owner=x and HREADY=1 (pending phase issued).
REQ-021 HWDATA = M[downer]_HWDATA.
REQ-022 At every HREADY=1 edge: downer<=owner; dactive<=bus HTRANS[1].
REQ-023 Mx_HREADY: pendx=1 -> 0; else if owner=x or (dactive and downer=x) -> HREADY; else 1.
REQ-024 bcnt loads beats-1 (3/7/15) on a bus NONSEQ with fixed-length HBURST at an HREADY=1 edge, and decrements on each bus SEQ at an HREADY=1 edge.
REQ-025 A decision edge is an HREADY=1 edge where the bus HTRANS is any of: IDLE; NONSEQ with HBURST=SINGLE; SEQ with bcnt=1 in a fixed-length burst.
REQ-026 Bus HTRANS=BUSY, or any beat of an INCR burst other than IDLE, is never a decision edge.
REQ-027 reqx = pendx | Mx_HTRANS[1].
REQ-028 ARB_RR=1 at a decision edge: owner<=other if req(other), else unchanged.
REQ-029 ARB_RR=0 at a decision edge: owner<=0 if req0, else 1 if req1, else unchanged.
REQ-030 Owner never changes outside decision edges; switch latency from request to bus issue is at most one decision edge plus one cycle.
REQ-031 Simultaneous non-owner capture and ownership switch to that master at the same edge: capture still occurs; PEND is issued the next cycle.

Reset
REQ-032 HRESET=1 at an edge, regardless of HREADY or burst state: owner=0, downer=0, dactive=0, pend0=pend1=0, bcnt=0.
REQ-033 Outputs while in reset state: HMASTER=0, bus outputs follow M0 live signals, M0_HREADY=HREADY, M1_HREADY=1.
REQ-034 Reset mid-burst discards PEND contents and bcnt; no pending transfer is replayed.

Verification
REQ-035 M0 single read 0x0000_0010, M1 idle -> bus HADDR=0x10 same cycle, M0_HRDATA=HRDATA, HMASTER stays 0.
REQ-036 M1 NONSEQ write 0x2000_0000 while M0 owner idle -> captured, M1_HREADY=0, HMASTER=1 next cycle, bus HADDR=0x2000_0000 HWRITE=1, HWDATA=M1_HWDATA in the following data phase.
REQ-037 M0 INCR4 burst, M1 requests at beat 2 -> four M0 beats uninterrupted, switch at edge of beat 4, M1 pending issued next cycle.
REQ-038 ARB_RR=1, both masters streaming SINGLE NONSEQ -> HMASTER alternates 0,1,0,1 on each decision edge; ARB_RR=0 -> HMASTER stays 0.
REQ-039 HREADY held 0 for 3 cycles during M1 data phase -> M1_HREADY=0 for those cycles, no owner change, pend/downer unchanged.
REQ-040 HRESET asserted mid M1 pending phase -> next cycle pend1=0, HMASTER=0, M1_HREADY=1.
